pool_relu_array: RTL
====================

# pool_relu_array

Parametrised 2x2/stride-2 pooling + ReLU stage for CH parallel feature-map channels, generalising the fixed 4-channel max-pool wrapper. It sits between the convolution engine output and the next layer's input buffer. It accepts one pixel per channel per cycle in row-major order. It emits one pooled pixel per channel per 2x2 window.
- Max or average pooling is selectable at elaboration.
- ReLU is optional.
- Odd dimensions are handled.
- Frame resynchronisation and an end-of-frame pulse are provided.

## Interface
- DATA_W, 32, signed sample width per channel
- CH, 4, number of parallel channels
- W, 26, input frame width in pixels (>=2)
- H, 26, input frame height in pixels (>=2)
- MODE, 0, 0 = max pooling, 1 = average pooling
- RELU_EN, 1, 1 = clamp negative results to 0, 0 = pass through
- iClk  in  1  clock, all logic on rising edge
- iRsn  in  1  reset, asynchronous, active-low
- iValid  in  1  pixel present for all channels this cycle
- iSof  in  1  start of frame, qualified by iValid
- iData  in  CH*DATA_W  packed signed pixels, channel k at bits [k*DATA_W +: DATA_W]
- oValid  out  1  pooled pixel valid, single-cycle pulse per window
- oData  out  CH*DATA_W  packed signed pooled pixels, same packing as iData
- oFrameDone  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- Counters: col 0..W-1 and row 0..H-1, both 0 after reset. They advance only on iValid. col wraps to 0 at W-1 and row increments. At (H-1, W-1), both wrap to 0.
- iSof with iValid: the pixel is treated as (0,0) regardless of counter state. Counters become (0,1) afterwards. A partially accumulated window is discarded.
- Horizontal pair, per channel: at even col, latch the pixel. At the following odd col, form pair = max(latched, current) in MODE 0, or sum in MODE 1.
- Line buffer: floor(W/2) entries x CH x (DATA_W+1) bits, indexed by col>>1. It is written with the pair result on even rows at odd col. It is read on odd rows at odd col.
- Window result, on odd row and odd col:
  - MODE 0: max(buffered pair, current pair), signed compare.
  - MODE 1: (sum of 4) >>> 2, computed in DATA_W+2 bits, arithmetic shift (floor toward minus infinity), then truncated to DATA_W. No overflow is possible.
- ReLU applies after pooling when RELU_EN=1: a negative result becomes 0.
- Odd W: column W-1 is ignored (no padding). Odd H: row H-1 is ignored. No output is produced for either.
- Output count per frame is floor(W/2)*floor(H/2), in row-major window order.
- iValid gaps of any length, inside or between rows, are legal. All state holds during a gap.

## Timing
- Reset values: oValid=0, oData=0, oFrameDone=0, col=0, row=0, pair latches=0. Line buffer contents are don't-care and are never output before being rewritten.
- Latency: oValid/oData are registered on the same rising edge that samples the window's bottom-right pixel. They are visible for exactly the following cycle.
- oData holds its last value when oValid=0.
- oFrameDone is registered on the edge sampling pixel (H-1, W-1). When W and H are even, it coincides with the last oValid.
- Reset asserted mid-frame: all outputs drop to 0 asynchronously. The next accepted pixel after release is (0,0).
- There is no backpressure. Throughput is 1 pixel/cycle sustained.

## Test plan
- W=26, H=28, CH=4, MODE 0, RELU_EN=1, random pixels in -10..10, continuous iValid -> 182 oValid pulses per channel. Each matches the golden max4+ReLU. No output is negative. oFrameDone fires once, on the edge of the 182nd output.
- Window {-7,-3,-9,-1}, MODE 0 -> 0 with RELU_EN=1. The same window gives -1 with RELU_EN=0.
- MODE 1, RELU_EN=0, window {5,6,7,-20} -> -1 (sum -2 >>> 2). Window {DATA_W max} x4 -> max positive value, no wrap.
- W=5, H=5, continuous input -> exactly 4 outputs, at pixels (1,1), (1,3), (3,1), (3,3). Column 4 and row 4 produce nothing. oFrameDone fires at (4,4).
- Random 1-3 cycle iValid gaps inserted, plus iSof reasserted at mid-frame pixel (3,7) -> outputs are identical to the gap-free stream. The frame restarts from that pixel as (0,0), and the old partial window never appears.
- iRsn pulsed low at row 10 -> oValid/oData drop to 0 immediately. A fresh frame after release produces the full correct output sequence.

Source files
------------

// File: rtl/pool_relu_array.sv
// 2x2 stride-2 max/average pooling with optional ReLU across CH parallel channels.
// Shared col/row sequencing in the top; per-channel datapath in pool_relu_lane.

module pool_relu_lane #(
  parameter int DATA_W  = 32,
  parameter int NP      = 13,
  parameter int IW      = 4,
  parameter int MODE    = 0,
  parameter int RELU_EN = 1
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              lat_en_i,
  input  logic              wr_en_i,
  input  logic              out_en_i,
  input  logic [IW-1:0]     idx_i,
  input  logic [DATA_W-1:0] px_i,
  output logic [DATA_W-1:0] dat_o
);
  localparam int PW = DATA_W + 1;
  localparam int SW = DATA_W + 2;

  logic signed [DATA_W-1:0] lat_q, px, res, pooled, dat_q, dat_d;
  logic signed [PW-1:0]     pair, bufp;
  logic signed [PW-1:0]     lbuf [NP];

  assign px   = px_i;
  assign bufp = lbuf[idx_i];

  generate
    if (MODE == 0) begin : g_max
      logic signed [PW-1:0] win;
      assign pair   = (lat_q > px) ? {lat_q[DATA_W-1], lat_q} : {px[DATA_W-1], px};
      assign win    = (bufp > pair) ? bufp : pair;
      assign pooled = DATA_W'(win);
    end else begin : g_avg
      // Four DATA_W samples fit in DATA_W+2 bits, so the sum never wraps.
      logic signed [SW-1:0] sum4;
      assign pair   = {lat_q[DATA_W-1], lat_q} + {px[DATA_W-1], px};
      assign sum4   = {bufp[PW-1], bufp} + {pair[PW-1], pair};
      assign pooled = DATA_W'(sum4 >>> 2);
    end
  endgenerate

  assign res   = (RELU_EN != 0 && pooled[DATA_W-1]) ? '0 : pooled;
  assign dat_d = out_en_i ? res : dat_q;
  assign dat_o = dat_q;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      lat_q <= '0;
      dat_q <= '0;
    end else begin
      if (lat_en_i) lat_q <= px;
      dat_q <= dat_d;
    end
  end

  // Line buffer carries no reset: every entry is rewritten on an even row before use.
  always_ff @(posedge iClk) begin
    if (wr_en_i) lbuf[idx_i] <= pair;
  end
endmodule

module pool_relu_array #(
  parameter int DATA_W  = 32,
  parameter int CH      = 4,
  parameter int W       = 26,
  parameter int H       = 26,
  parameter int MODE    = 0,
  parameter int RELU_EN = 1
) (
  input  logic                 iClk,
  input  logic                 iRsn,
  input  logic                 iValid,
  input  logic                 iSof,
  input  logic [CH*DATA_W-1:0] iData,
  output logic                 oValid,
  output logic [CH*DATA_W-1:0] oData,
  output logic                 oFrameDone
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int NP = W / 2;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;

  logic [CW-1:0] col_q, col_d, col_c;
  logic [RW-1:0] row_q, row_d, row_c;
  logic          last_col, last_row;
  logic          lat_en, pair_en, wr_en, out_en;
  logic          vld_q, done_q;
  logic [IW-1:0] idx;
  logic [CH-1:0][DATA_W-1:0] px, lane_q;

  // iSof forces the current pixel to (0,0) whatever the counters say.
  assign col_c    = iSof ? '0 : col_q;
  assign row_c    = iSof ? '0 : row_q;
  assign last_col = (col_c == CW'(W - 1));
  assign last_row = (row_c == RW'(H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (iValid) begin
      col_d = last_col ? '0 : col_c + CW'(1);
      row_d = last_col ? (last_row ? '0 : row_c + RW'(1)) : row_c;
    end
  end

  // With odd W/H the trailing column/row is even-indexed, so it never closes a pair or window.
  assign lat_en  = iValid & ~col_c[0];
  assign pair_en = iValid &  col_c[0];
  assign wr_en   = pair_en & ~row_c[0];
  assign out_en  = pair_en &  row_c[0];
  assign idx     = IW'(col_c >> 1);
  assign px      = iData;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      vld_q  <= out_en;
      done_q <= iValid & last_col & last_row;
    end
  end

  generate
    for (genvar k = 0; k < CH; k++) begin : g_lane
      pool_relu_lane #(
        .DATA_W(DATA_W), .NP(NP), .IW(IW), .MODE(MODE), .RELU_EN(RELU_EN)
      ) u_lane (
        .iClk     (iClk),
        .iRsn     (iRsn),
        .lat_en_i (lat_en),
        .wr_en_i  (wr_en),
        .out_en_i (out_en),
        .idx_i    (idx),
        .px_i     (px[k]),
        .dat_o    (lane_q[k])
      );
    end
  endgenerate

  assign oValid     = vld_q;
  assign oData      = lane_q;
  assign oFrameDone = done_q;
endmodule
